digit_editor: RTL and testbench

Parametrised multi-digit value editor for the stopwatch front panel. While `edit_en` is high it owns a NUM_DIGITS-digit mixed-radix value. Each digit has its own base; a cursor is moved with left/right and the digit under it is stepped with up/down. Up/down support carry/borrow and auto-repeat, and the selected digit blinks on the anode mask. The block sits between the debounced push-buttons, the time counters (load/commit) and the seven-segment scanner (digit blanking).

---
 rtl/stopwatch_pkg.sv | 18 +
 rtl/digit_editor_btn_repeat.sv | 65 ++++++
 rtl/digit_editor.sv | 178 +++++++++++++++++
 tb/tb_digit_editor.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: default MM:SS digit bases, digit type and
// the editor state encoding.
package stopwatch_pkg;

    localparam int SW_DIGIT_W    = 4;
    localparam int SW_NUM_DIGITS = 4;

    // Digit 0 is seconds units, digit 3 is tens of minutes.
    localparam logic [SW_DIGIT_W*SW_NUM_DIGITS-1:0] SW_BASES = {4'd6, 4'd10, 4'd6, 4'd10};

    typedef logic [SW_DIGIT_W-1:0] digit_t;

    typedef enum logic {
        IDLE = 1'b0,
        EDIT = 1'b1
    } state_e;

endpackage

// File: rtl/digit_editor_btn_repeat.sv
// Rising-edge detector for a debounced button with optional hold-to-repeat.
// fire pulses on the press edge, again REPEAT_DELAY cycles later if still
// held, then every REPEAT_PERIOD cycles until release. clr suppresses fire and
// keeps the timers idle; the edge detector keeps tracking so a button already
// held when clr drops does not count as a fresh press.
module btn_repeat #(
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic clr,
    output logic fire
);

    localparam int CMAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W = $clog2(CMAX + 1);
    localparam logic [CNT_W-1:0] DLY_C = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PER_C = CNT_W'(REPEAT_PERIOD);

    logic             btn_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rep_q, rep_d;
    logic             rise, rep_fire;

    // Timer: 0 = idle, otherwise cycles since the last step (press or repeat).
    always_comb begin
        rise     = btn & ~btn_q;
        cnt_d    = cnt_q;
        rep_d    = rep_q;
        rep_fire = 1'b0;
        if (clr || !btn || !REPEAT_EN) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (rise) begin
            cnt_d = CNT_W'(1);
            rep_d = 1'b0;
        end else if (cnt_q != '0) begin
            if (cnt_q == (rep_q ? PER_C : DLY_C)) begin
                rep_fire = 1'b1;
                cnt_d    = CNT_W'(1);
                rep_d    = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        fire = ~clr & (rise | rep_fire);
    end

    // Edge-detect history and repeat timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= 1'b0;
            cnt_q <= '0;
            rep_q <= 1'b0;
        end else begin
            btn_q <= btn;
            cnt_q <= cnt_d;
            rep_q <= rep_d;
        end
    end

endmodule

// File: rtl/digit_editor.sv
// Mixed-radix multi-digit value editor for the stopwatch front panel.
// Owns the value while edit_en is high; cursor moves with left/right, the
// cursor digit steps with up/down (with carry/borrow and auto-repeat) and
// blinks on the active-low anode mask.
module digit_editor
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS    = SW_NUM_DIGITS,
    parameter int DIGIT_W       = SW_DIGIT_W,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0] BASES = SW_BASES,
    parameter int CARRY_MODE    = 1,
    parameter int CURSOR_WRAP   = 0,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int BLINK_HALF    = 25_000_000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            edit_en,
    input  logic                            btn_up,
    input  logic                            btn_down,
    input  logic                            btn_left,
    input  logic                            btn_right,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]   load_value,
    output logic [DIGIT_W*NUM_DIGITS-1:0]   value,
    output logic                            commit,
    output logic [$clog2(NUM_DIGITS)-1:0]   cursor,
    output logic [NUM_DIGITS-1:0]           an_mask_n
);

    localparam int VW = DIGIT_W * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [CW-1:0] TOP = CW'(NUM_DIGITS - 1);

    state_e          state_q, state_d;
    logic [VW-1:0]   value_q, value_d;
    logic [CW-1:0]   cursor_q, cursor_d;
    logic            commit_q, commit_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            blink_off_q, blink_off_d;

    logic [VW-1:0]   inc_val, dec_val, load_san, max_val;
    logic            carry_top, borrow_top;
    logic            in_edit, ud_clr, lr_clr;
    logic            up_fire, dn_fire, l_fire, r_fire, mv_l, mv_r, act_any;

    assign in_edit = (state_q == EDIT);
    // Pressing up and down together cancels both steps and both repeat timers.
    assign ud_clr  = ~in_edit | (btn_up & btn_down);
    assign lr_clr  = ~in_edit;

    btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1))
        u_up    (.clk(clk), .rst_n(rst_n), .btn(btn_up),    .clr(ud_clr), .fire(up_fire));
    btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1))
        u_down  (.clk(clk), .rst_n(rst_n), .btn(btn_down),  .clr(ud_clr), .fire(dn_fire));
    btn_repeat #(.REPEAT_DELAY(1), .REPEAT_PERIOD(1), .REPEAT_EN(1'b0))
        u_left  (.clk(clk), .rst_n(rst_n), .btn(btn_left),  .clr(lr_clr), .fire(l_fire));
    btn_repeat #(.REPEAT_DELAY(1), .REPEAT_PERIOD(1), .REPEAT_EN(1'b0))
        u_right (.clk(clk), .rst_n(rst_n), .btn(btn_right), .clr(lr_clr), .fire(r_fire));

    assign mv_l    = l_fire & ~r_fire;
    assign mv_r    = r_fire & ~l_fire;
    assign act_any = up_fire | dn_fire | mv_l | mv_r;

    // Per-digit step logic. A base field of 0 encodes base 2^DIGIT_W, which
    // makes DMAX all ones. Carry/borrow enters at the cursor digit and ripples
    // upward combinationally when CARRY_MODE is set.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
        localparam logic [DIGIT_W-1:0] DMAX = DIGIT_W'(BASES[gi*DIGIT_W +: DIGIT_W] - 1);
        logic [DIGIT_W-1:0] d, ld;
        logic               sel, cin, cout, bin, bout;

        assign d   = value_q[gi*DIGIT_W +: DIGIT_W];
        assign ld  = load_value[gi*DIGIT_W +: DIGIT_W];
        assign sel = (cursor_q == CW'(gi));

        if (gi == 0 || CARRY_MODE == 0) begin : g_local
            assign cin = sel;
            assign bin = sel;
        end else begin : g_chain
            assign cin = sel | g_dig[gi-1].cout;
            assign bin = sel | g_dig[gi-1].bout;
        end

        assign cout = cin & (d == DMAX);
        assign bout = bin & (d == '0);

        assign inc_val[gi*DIGIT_W +: DIGIT_W]  = !cin ? d : ((d == DMAX) ? '0 : d + 1'b1);
        assign dec_val[gi*DIGIT_W +: DIGIT_W]  = !bin ? d : ((d == '0) ? DMAX : d - 1'b1);
        assign load_san[gi*DIGIT_W +: DIGIT_W] = (ld > DMAX) ? '0 : ld;
        assign max_val[gi*DIGIT_W +: DIGIT_W]  = DMAX;

        // Selected digit follows the blink phase; all digits lit outside edit.
        assign an_mask_n[gi] = in_edit ? (sel ? blink_off_q : 1'b1) : 1'b0;
    end

    assign carry_top  = (CARRY_MODE != 0) && g_dig[NUM_DIGITS-1].cout;
    assign borrow_top = (CARRY_MODE != 0) && g_dig[NUM_DIGITS-1].bout;

    // Next-state: edit entry/exit, value steps, cursor moves and blink phase.
    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        cursor_d    = cursor_q;
        commit_d    = 1'b0;
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        case (state_q)
            IDLE: begin
                if (edit_en) begin
                    state_d     = EDIT;
                    value_d     = load_san;
                    cursor_d    = TOP;
                    blink_cnt_d = '0;
                    blink_off_d = 1'b0;
                end
            end
            EDIT: begin
                if (!edit_en) begin
                    state_d     = IDLE;
                    commit_d    = 1'b1;
                    blink_cnt_d = '0;
                    blink_off_d = 1'b0;
                end else begin
                    if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
                        blink_cnt_d = '0;
                        blink_off_d = ~blink_off_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                    // Step uses the current cursor; any move lands afterwards.
                    if (up_fire) begin
                        value_d = carry_top ? '0 : inc_val;
                    end else if (dn_fire) begin
                        value_d = borrow_top ? max_val : dec_val;
                    end
                    if (mv_l) begin
                        cursor_d = (cursor_q == TOP) ? ((CURSOR_WRAP != 0) ? '0 : TOP)
                                                     : cursor_q + 1'b1;
                    end else if (mv_r) begin
                        cursor_d = (cursor_q == '0) ? ((CURSOR_WRAP != 0) ? TOP : '0)
                                                    : cursor_q - 1'b1;
                    end
                    if (act_any) begin
                        blink_cnt_d = '0;
                        blink_off_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            value_q     <= '0;
            cursor_q    <= TOP;
            commit_q    <= 1'b0;
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            cursor_q    <= cursor_d;
            commit_q    <= commit_d;
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end

    assign value  = value_q;
    assign commit = commit_q;
    assign cursor = cursor_q;

endmodule

// File: tb/tb_digit_editor.sv
// Directed bench for digit_editor: three instances (default, no-carry,
// cursor-wrap) share one stimulus stream with short repeat/blink timings.
module tb_digit_editor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        edit_en = 1'b0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [15:0] load_value = 16'h0000;

    logic [15:0] v0, v1, v2;
    logic        c0, c1, c2;
    logic [1:0]  cur0, cur1, cur2;
    logic [3:0]  m0, m1, m2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    digit_editor #(.REPEAT_DELAY(8), .REPEAT_PERIOD(3), .BLINK_HALF(4)) dut (
        .clk(clk), .rst_n(rst_n), .edit_en(edit_en), .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right), .load_value(load_value),
        .value(v0), .commit(c0), .cursor(cur0), .an_mask_n(m0));

    digit_editor #(.CARRY_MODE(0), .REPEAT_DELAY(8), .REPEAT_PERIOD(3), .BLINK_HALF(4)) dut_nc (
        .clk(clk), .rst_n(rst_n), .edit_en(edit_en), .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right), .load_value(load_value),
        .value(v1), .commit(c1), .cursor(cur1), .an_mask_n(m1));

    digit_editor #(.CURSOR_WRAP(1), .REPEAT_DELAY(8), .REPEAT_PERIOD(3), .BLINK_HALF(4)) dut_wr (
        .clk(clk), .rst_n(rst_n), .edit_en(edit_en), .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right), .load_value(load_value),
        .value(v2), .commit(c2), .cursor(cur2), .an_mask_n(m2));

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; edit_en = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic enter(input logic [15:0] v);
        load_value = v;
        edit_en = 1'b1;
        tick(1);
        $display("txn enter load=%h: value=%h cursor=%0d", v, v0, cur0);
    endtask

    task automatic leave();
        edit_en = 1'b0;
        tick(1);
        $display("txn leave: value=%h commit=%b", v0, c0);
    endtask

    // which: 0 up, 1 down, 2 left, 3 right
    task automatic pulse(input int which);
        case (which)
            0: btn_up = 1'b1;
            1: btn_down = 1'b1;
            2: btn_left = 1'b1;
            default: btn_right = 1'b1;
        endcase
        tick(1);
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        tick(1);
        $display("txn press %0d: value=%h cursor=%0d", which, v0, cur0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(1);
        n_checks++; if (v0 !== 16'h0000) begin n_fail++; $display("FAIL reset_value: got %h want 0000", v0); end
        n_checks++; if (cur0 !== 2'd3) begin n_fail++; $display("FAIL reset_cursor: got %0d want 3", cur0); end
        n_checks++; if (c0 !== 1'b0) begin n_fail++; $display("FAIL reset_commit: got %b want 0", c0); end
        n_checks++; if (m0 !== 4'b0000) begin n_fail++; $display("FAIL reset_mask: got %b want 0000", m0); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_carry();
        do_reset();
        enter(16'h0959);
        n_checks++; if (v0 !== 16'h0959) begin n_fail++; $display("FAIL load_value: got %h want 0959", v0); end
        n_checks++; if (cur0 !== 2'd3) begin n_fail++; $display("FAIL entry_cursor: got %0d want 3", cur0); end
        n_checks++; if (m0 !== 4'b0111) begin n_fail++; $display("FAIL entry_mask: got %b want 0111", m0); end
        for (int i = 0; i < 3; i++) pulse(3);
        n_checks++; if (cur0 !== 2'd0) begin n_fail++; $display("FAIL cursor_to_0: got %0d want 0", cur0); end
        pulse(0);
        n_checks++; if (v0 !== 16'h1000) begin n_fail++; $display("FAIL carry_up: got %h want 1000", v0); end
        n_checks++; if (v1 !== 16'h0950) begin n_fail++; $display("FAIL nocarry_up: got %h want 0950", v1); end
        pulse(1);
        n_checks++; if (v0 !== 16'h0959) begin n_fail++; $display("FAIL borrow_down: got %h want 0959", v0); end
        n_checks++; if (v1 !== 16'h0959) begin n_fail++; $display("FAIL nocarry_down: got %h want 0959", v1); end
        leave();
    endtask

    task automatic test_wrap();
        do_reset();
        enter(16'h5959);
        for (int i = 0; i < 3; i++) pulse(3);
        pulse(0);
        n_checks++; if (v0 !== 16'h0000) begin n_fail++; $display("FAIL top_carry_wrap: got %h want 0000", v0); end
        n_checks++; if (v1 !== 16'h5950) begin n_fail++; $display("FAIL nc_wrap_up: got %h want 5950", v1); end
        pulse(1);
        n_checks++; if (v0 !== 16'h5959) begin n_fail++; $display("FAIL top_borrow_wrap: got %h want 5959", v0); end
        n_checks++; if (v1 !== 16'h5959) begin n_fail++; $display("FAIL nc_wrap_down: got %h want 5959", v1); end
        leave();
    endtask

    task automatic test_nocarry();
        do_reset();
        enter(16'h0059);
        for (int i = 0; i < 3; i++) pulse(3);
        pulse(0);
        n_checks++; if (v1 !== 16'h0050) begin n_fail++; $display("FAIL nocarry_0059: got %h want 0050", v1); end
        n_checks++; if (v0 !== 16'h0100) begin n_fail++; $display("FAIL carry_0059: got %h want 0100", v0); end
        leave();
        enter(16'hF9A7);
        n_checks++; if (v0 !== 16'h0907) begin n_fail++; $display("FAIL load_sanitise: got %h want 0907", v0); end
        leave();
    endtask

    task automatic test_repeat();
        logic [15:0] exp_v;
        do_reset();
        enter(16'h0000);
        for (int i = 0; i < 3; i++) pulse(3);
        btn_up = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            exp_v = 16'(int'(k >= 1) + int'(k >= 9) + int'(k >= 12) + int'(k >= 15) + int'(k >= 18));
            n_checks++;
            if (v0 !== exp_v) begin n_fail++; $display("FAIL repeat_cycle_%0d: got %h want %h", k, v0, exp_v); end
        end
        btn_up = 1'b0;
        tick(10);
        $display("txn hold up 20 cycles: value=%h", v0);
        n_checks++; if (v0 !== 16'h0005) begin n_fail++; $display("FAIL repeat_release: got %h want 0005", v0); end
        leave();
    endtask

    task automatic test_cursor();
        do_reset();
        enter(16'h0000);
        pulse(2);
        n_checks++; if (cur0 !== 2'd3) begin n_fail++; $display("FAIL sat_left_1: got %0d want 3", cur0); end
        n_checks++; if (cur2 !== 2'd0) begin n_fail++; $display("FAIL wrap_left_1: got %0d want 0", cur2); end
        pulse(2); pulse(2);
        n_checks++; if (cur0 !== 2'd3) begin n_fail++; $display("FAIL sat_left_3: got %0d want 3", cur0); end
        n_checks++; if (cur2 !== 2'd2) begin n_fail++; $display("FAIL wrap_left_3: got %0d want 2", cur2); end
        for (int i = 0; i < 4; i++) pulse(3);
        n_checks++; if (cur0 !== 2'd0) begin n_fail++; $display("FAIL sat_right: got %0d want 0", cur0); end
        n_checks++; if (cur2 !== 2'd2) begin n_fail++; $display("FAIL wrap_right: got %0d want 2", cur2); end
        leave();
    endtask

    task automatic test_blink();
        do_reset();
        enter(16'h0000);
        tick(3);
        n_checks++; if (m0 !== 4'b0111) begin n_fail++; $display("FAIL blink_on_end: got %b want 0111", m0); end
        tick(1);
        n_checks++; if (m0 !== 4'b1111) begin n_fail++; $display("FAIL blink_off: got %b want 1111", m0); end
        tick(4);
        n_checks++; if (m0 !== 4'b0111) begin n_fail++; $display("FAIL blink_on_again: got %b want 0111", m0); end
        tick(4);
        btn_right = 1'b1;
        tick(1);
        n_checks++; if (m0 !== 4'b1011) begin n_fail++; $display("FAIL blink_restart: got %b want 1011", m0); end
        btn_right = 1'b0;
        tick(1);
        n_checks++; if (m0 !== 4'b1011) begin n_fail++; $display("FAIL blink_restart_hold: got %b want 1011", m0); end
        leave();
    endtask

    task automatic test_back_to_back();
        do_reset();
        enter(16'h0959);
        for (int i = 0; i < 3; i++) pulse(3);
        btn_up = 1'b1; btn_down = 1'b1;
        tick(12);
        btn_up = 1'b0; btn_down = 1'b0;
        tick(2);
        $display("txn up+down held: value=%h", v0);
        n_checks++; if (v0 !== 16'h0959) begin n_fail++; $display("FAIL up_down_cancel: got %h want 0959", v0); end
        btn_left = 1'b1; btn_right = 1'b1;
        tick(1);
        btn_left = 1'b0; btn_right = 1'b0;
        tick(1);
        n_checks++; if (cur0 !== 2'd0) begin n_fail++; $display("FAIL left_right_cancel: got %0d want 0", cur0); end
        btn_up = 1'b1; btn_left = 1'b1;
        tick(1);
        btn_up = 1'b0; btn_left = 1'b0;
        n_checks++; if (v0 !== 16'h1000) begin n_fail++; $display("FAIL step_old_cursor: got %h want 1000", v0); end
        n_checks++; if (cur0 !== 2'd1) begin n_fail++; $display("FAIL move_after_step: got %0d want 1", cur0); end
        tick(1);
        pulse(0);
        n_checks++; if (v0 !== 16'h1010) begin n_fail++; $display("FAIL step_new_cursor: got %h want 1010", v0); end
        leave();
    endtask

    task automatic test_reset_mid();
        do_reset();
        enter(16'h0959);
        btn_up = 1'b1;
        tick(5);
        #2;
        rst_n = 1'b0;
        edit_en = 1'b0;
        btn_up = 1'b0;
        #1;
        $display("txn reset mid-hold: value=%h commit=%b", v0, c0);
        n_checks++; if (v0 !== 16'h0000) begin n_fail++; $display("FAIL async_reset_value: got %h want 0000", v0); end
        n_checks++; if (cur0 !== 2'd3) begin n_fail++; $display("FAIL async_reset_cursor: got %0d want 3", cur0); end
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (i == 1) rst_n = 1'b1;
            n_checks++; if (c0 !== 1'b0) begin n_fail++; $display("FAIL reset_no_commit_%0d: got %b want 0", i, c0); end
        end
        n_checks++; if (v0 !== 16'h0000) begin n_fail++; $display("FAIL reset_value_after: got %h want 0000", v0); end
    endtask

    task automatic test_commit();
        do_reset();
        enter(16'h0959);
        pulse(0);
        n_checks++; if (v0 !== 16'h1959) begin n_fail++; $display("FAIL step_cursor3: got %h want 1959", v0); end
        n_checks++; if (c0 !== 1'b0) begin n_fail++; $display("FAIL commit_early: got %b want 0", c0); end
        leave();
        n_checks++; if (c0 !== 1'b1) begin n_fail++; $display("FAIL commit_pulse: got %b want 1", c0); end
        n_checks++; if (m0 !== 4'b0000) begin n_fail++; $display("FAIL idle_mask: got %b want 0000", m0); end
        n_checks++; if (v0 !== 16'h1959) begin n_fail++; $display("FAIL commit_value: got %h want 1959", v0); end
        tick(1);
        n_checks++; if (c0 !== 1'b0) begin n_fail++; $display("FAIL commit_one_cycle: got %b want 0", c0); end
        n_checks++; if (v0 !== 16'h1959) begin n_fail++; $display("FAIL value_holds: got %h want 1959", v0); end
        pulse(0);
        n_checks++; if (v0 !== 16'h1959) begin n_fail++; $display("FAIL idle_ignores_btn: got %h want 1959", v0); end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_wrap();
        test_nocarry();
        test_repeat();
        test_cursor();
        test_blink();
        test_back_to_back();
        test_reset_mid();
        test_commit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
